// File: rtl/cnn_pkg.sv
// Shared CNN accelerator definitions: DRAM bus widths and arbiter state encoding.
package cnn_pkg;

    localparam int unsigned DRAM_ADDR_W = 10;
    localparam int unsigned DRAM_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } arbState_t;

    typedef struct packed {
        logic                   we;
        logic [DRAM_ADDR_W-1:0] addr;
        logic [DRAM_DATA_W-1:0] data;
    } dramCmd_t;

endpackage

// File: rtl/dram_arbiter.sv
// Two-requester DRAM arbiter (ifmap reads vs. pooled-result writes) with registered commands.
// Conflicts go to the write requester unless DRAM_ARB_RR_EN selects round-robin.
module dram_arbiter
    import cnn_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdReq,
    input  logic [DRAM_ADDR_W-1:0] rdAddr,
    input  logic                   wrReq,
    input  logic [DRAM_ADDR_W-1:0] wrAddr,
    input  logic [DRAM_DATA_W-1:0] wrData,
    input  logic [DRAM_DATA_W-1:0] dramRdata,
    output logic                   rdGnt,
    output logic                   wrGnt,
    output logic                   rdValid,
    output logic [DRAM_DATA_W-1:0] rdData,
    output logic                   DRAMen,
    output logic                   DRAMwe,
    output logic [DRAM_ADDR_W-1:0] DRAMaddr,
    output logic [DRAM_DATA_W-1:0] DRAMwdata
);

    arbState_t state;
    logic      armed;
    logic      rdElig;
    logic      wrElig;
    logic      pickRd;
    logic      pickWr;
    dramCmd_t  nextCmd;

`ifdef DRAM_ARB_RR_EN
    logic      rrPrefWr;
`endif

    assign rdData = dramRdata;

    // The current state doubles as the eligibility mask: a requester whose command is
    // on the bus this cycle cannot win again at the next edge.
    always_comb begin
        rdElig = armed && rdReq && (state != RD);
        wrElig = armed && wrReq && (state != WR);
        pickRd = 1'b0;
        pickWr = 1'b0;
        if (rdElig && wrElig) begin
`ifdef DRAM_ARB_RR_EN
            pickWr = rrPrefWr;
            pickRd = ~rrPrefWr;
`else
            pickWr = 1'b1;
`endif
        end else begin
            pickRd = rdElig;
            pickWr = wrElig;
        end
    end

    always_comb begin
        nextCmd = '0;
        if (pickWr) begin
            nextCmd.we   = 1'b1;
            nextCmd.addr = wrAddr;
            nextCmd.data = wrData;
        end else if (pickRd) begin
            nextCmd.addr = rdAddr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            armed     <= 1'b0;
            rdGnt     <= 1'b0;
            wrGnt     <= 1'b0;
            rdValid   <= 1'b0;
            DRAMen    <= 1'b0;
            DRAMwe    <= 1'b0;
            DRAMaddr  <= '0;
            DRAMwdata <= '0;
`ifdef DRAM_ARB_RR_EN
            rrPrefWr  <= 1'b0;
`endif
        end else begin
            // One dead edge after reset release keeps the first grant off the first edge.
            armed     <= 1'b1;
            rdValid   <= (state == RD);
            rdGnt     <= pickRd;
            wrGnt     <= pickWr;
            DRAMen    <= pickRd | pickWr;
            DRAMwe    <= nextCmd.we;
            DRAMaddr  <= nextCmd.addr;
            DRAMwdata <= nextCmd.data;
            if (pickWr) begin
                state <= WR;
            end else if (pickRd) begin
                state <= RD;
            end else begin
                state <= IDLE;
            end
`ifdef DRAM_ARB_RR_EN
            if (pickRd) begin
                rrPrefWr <= 1'b1;
            end else if (pickWr) begin
                rrPrefWr <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the clock and reset ports SHALL be the first two ports, in the order below.
REQ-002 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 rdReq  input  1  ifmap fetch request from the controller; held high until rdGnt.
REQ-005 rdAddr  input  10  ifmap read word address; stable while rdReq is high.
REQ-006 wrReq  input  1  pooled-result write request from the output FIFO; held high until wrGnt.
REQ-007 wrAddr  input  10  write word address; stable while wrReq is high.
REQ-008 wrData  input  64  write data; stable while wrReq is high.
REQ-009 dramRdata  input  64  DRAM read data, valid one cycle after a read command.
REQ-010 rdGnt  output  1  one-cycle pulse: read request accepted.
REQ-011 wrGnt  output  1  one-cycle pulse: write request accepted.
REQ-012 rdValid  output  1  one-cycle pulse: rdData carries the granted read's word.
REQ-013 rdData  output  64  equals dramRdata (combinational pass-through).
REQ-014 DRAMen  output  1  DRAM command valid.
REQ-015 DRAMwe  output  1  1 = write command, 0 = read command.
REQ-016 DRAMaddr  output  10  DRAM command address.
REQ-017 DRAMwdata  output  64  DRAM write data; zero on non-write cycles.

Function
REQ-018 The FSM SHALL have three states: IDLE (no command), RD (read command issued), WR (write command issued); the state is re-evaluated every cycle.
REQ-019 The block SHALL sample requests in cycle N and, in cycle N+1, drive the registered DRAM command together with the matching grant pulse.
REQ-020 A requester granted in cycle N SHALL be ineligible in cycle N+1, so a request still held during its grant cycle is never granted twice.
REQ-021 When exactly one requester is eligible, that requester SHALL be granted.
REQ-022 When both requesters are eligible, arbitration SHALL follow REQ-031/REQ-032.
REQ-023 rdValid SHALL pulse in cycle N+2 for a read granted in cycle N+1; back-to-back reads separated by one idle cycle SHALL each produce exactly one rdValid.
REQ-024 With no eligible requester, the FSM SHALL return to IDLE; in IDLE, DRAMen=0, DRAMwe=0, DRAMaddr=0, DRAMwdata=0.
REQ-025 A request that drops before its grant SHALL be ignored; the block SHALL issue no command for it.
REQ-026 rdGnt and wrGnt SHALL never be high in the same cycle, and the DRAM SHALL receive at most one command per cycle.

Reset
REQ-027 Asserting rst SHALL immediately force state=IDLE and drive all outputs to 0 except rdData, which follows dramRdata.
REQ-028 Asserting rst SHALL also clear the eligibility masks, the pending-rdValid flag and the round-robin pointer.
REQ-029 A read granted before a mid-operation reset SHALL produce no rdValid after reset deasserts.
REQ-030 The first grant SHALL occur no earlier than the second rising edge after rst deasserts.

Configuration
REQ-031 With DRAM_ARB_RR_EN defined, a conflict (both eligible) SHALL be resolved round-robin: grant the requester not granted most recently; the pointer resets to favour read.
REQ-032 With DRAM_ARB_RR_EN undefined, a conflict SHALL always be granted to the write requester (fixed priority), and the round-robin pointer SHALL not exist.

Structure
REQ-033 The shared package cnn_pkg SHALL hold DRAM_ADDR_W=10, DRAM_DATA_W=64 and the arbiter state encoding (IDLE=2'd0, RD=2'd1, WR=2'd2).
REQ-034 The block SHALL be a single module with no sub-modules.

Verification
REQ-035 Read only: rdReq=1, rdAddr=10'h015 -> rdGnt, then DRAMen=1, DRAMwe=0, DRAMaddr=0x015 one cycle after request; rdValid next cycle with rdData=dramRdata.
REQ-036 Write only: wrReq=1, wrAddr=10'h3F0, wrData=64'hDEAD_BEEF_0000_0001 -> wrGnt, DRAMwe=1 and matching address/data in the same cycle.
REQ-037 Conflict, RR undefined: rdReq and wrReq held high together for 6 cycles -> grants alternate W, R, W, R... through REQ-020 eligibility; the first grant is write.
REQ-038 Conflict, RR defined, from reset: first grant is read, second is write, and grants strictly alternate.
REQ-039 Held request: rdReq held high 4 cycles -> exactly 2 rdGnt pulses, never in consecutive cycles, with 2 rdValid pulses.
REQ-040 Reset mid-read: rst asserted in the rdGnt cycle -> all outputs 0 at once; no rdValid after release; next request serviced normally.
